// File: rtl/io_stream_loader_pkg.sv
// Shared state encodings and config-slot indices for the pad stream loader.
package loader_pkg;

    typedef enum logic [2:0] {
        CFG      = 3'd0,
        INSTR    = 3'd1,
        DATA_IN  = 3'd2,
        COMPUTE  = 3'd3,
        DATA_OUT = 3'd4
    } ldr_state_t;

    // Sub-steps of one outbound word: read, capture, low half, high half.
    typedef enum logic [1:0] {
        OUT_RD  = 2'd0,
        OUT_CAP = 2'd1,
        OUT_LO  = 2'd2,
        OUT_HI  = 2'd3
    } out_step_t;

    localparam int CFG_NINSTR  = 0;
    localparam int CFG_NIN     = 1;
    localparam int CFG_INBASE  = 2;
    localparam int CFG_NOUT    = 3;
    localparam int CFG_OUTBASE = 4;

endpackage

// File: rtl/io_stream_loader_packer.sv
// Joins two consecutive inbound half-words (low first) into one 32-bit word,
// pulsing word_vld_o for one cycle right after the high half is accepted.
module half_word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        hw_vld_i,
    input  logic [15:0] hw_data_i,
    output logic        phase_o,
    output logic        word_vld_o,
    output logic [31:0] word_o
);

    logic        phase_q;
    logic        word_vld_q;
    logic [15:0] lo_q;
    logic [31:0] word_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q    <= 1'b0;
            word_vld_q <= 1'b0;
            lo_q       <= '0;
            word_q     <= '0;
        end else begin
            word_vld_q <= 1'b0;
            if (clear_i) begin
                phase_q <= 1'b0;
            end else if (hw_vld_i) begin
                if (!phase_q) begin
                    lo_q    <= hw_data_i;
                    phase_q <= 1'b1;
                end else begin
                    word_q     <= {hw_data_i, lo_q};
                    word_vld_q <= 1'b1;
                    phase_q    <= 1'b0;
                end
            end
        end
    end

    assign phase_o    = phase_q;
    assign word_vld_o = word_vld_q;
    assign word_o     = word_q;

endmodule

// File: rtl/io_stream_loader.sv
// Chip-side endpoint of the 16-bit pad stream: loads config, instructions and
// data batches, starts the core, then streams results back as half-words.
module io_stream_loader
    import loader_pkg::*;
#(
    parameter int NUM_CONFIGS = 5,
    parameter int IADDR_W     = 8,
    parameter int DADDR_W     = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [15:0]        in_data,
    input  logic               in_vld,
    output logic               in_rdy,
    output logic [15:0]        out_data,
    output logic               out_vld,
    input  logic               out_rdy,
    output logic               instr_wen,
    output logic [IADDR_W-1:0] instr_addr,
    output logic [31:0]        instr_wdata,
    output logic               mem_wen,
    output logic               mem_ren,
    output logic [DADDR_W-1:0] mem_addr,
    output logic [31:0]        mem_wdata,
    input  logic [31:0]        mem_rdata,
    output logic               core_start,
    input  logic               core_done,
    output logic [2:0]         dbg_state_o
);

    localparam int IDX_W = $clog2(NUM_CONFIGS);

    // Both streams transfer on (vld & rdy) at posedge clk; a valid, once raised,
    // holds its data stable until the matching ready accepts it.
    ldr_state_t         state_q;
    out_step_t          step_q;
    logic [DADDR_W-1:0] cfg_q [NUM_CONFIGS];
    logic [IDX_W-1:0]   idx_q;
    logic [DADDR_W-1:0] cnt_q;
    logic [DADDR_W-1:0] cnt_d;
    logic               in_rdy_q;
    logic               core_start_q;
    logic               mem_ren_q;
    logic               out_vld_q;
    logic [31:0]        hold_q;

    logic               in_hs;
    logic               pk_phase;
    logic               pk_word_vld;
    logic [31:0]        pk_word;
    logic               in_last_word;

    assign in_hs = in_vld & in_rdy_q;
    assign cnt_d = cnt_q + 1'b1;

    half_word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (state_q == CFG),
        .hw_vld_i   (in_hs),
        .hw_data_i  (in_data),
        .phase_o    (pk_phase),
        .word_vld_o (pk_word_vld),
        .word_o     (pk_word)
    );

    // High half of the final batch word: stop accepting before the write lands.
    assign in_last_word = (state_q == DATA_IN) && in_hs && pk_phase &&
                          (cnt_q == cfg_q[CFG_NIN]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= CFG;
            step_q       <= OUT_RD;
            idx_q        <= '0;
            cnt_q        <= '0;
            for (int i = 0; i < NUM_CONFIGS; i++) cfg_q[i] <= '0;
            in_rdy_q     <= 1'b0;
            core_start_q <= 1'b0;
            mem_ren_q    <= 1'b0;
            out_vld_q    <= 1'b0;
            hold_q       <= '0;
        end else begin
            core_start_q <= 1'b0;
            mem_ren_q    <= 1'b0;
            case (state_q)
                CFG: begin
                    in_rdy_q <= 1'b1;
                    if (in_hs) begin
                        cfg_q[idx_q] <= in_data[DADDR_W-1:0];
                        if (idx_q == IDX_W'(NUM_CONFIGS - 1)) begin
                            idx_q   <= '0;
                            cnt_q   <= '0;
                            state_q <= INSTR;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                INSTR: begin
                    if (pk_word_vld) begin
                        if (cnt_q == cfg_q[CFG_NINSTR]) begin
                            cnt_q   <= '0;
                            state_q <= DATA_IN;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end
                DATA_IN: begin
                    if (in_last_word) in_rdy_q <= 1'b0;
                    if (pk_word_vld) begin
                        if (cnt_q == cfg_q[CFG_NIN]) begin
                            cnt_q        <= '0;
                            core_start_q <= 1'b1;
                            state_q      <= COMPUTE;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end
                COMPUTE: begin
                    if (core_done) begin
                        cnt_q     <= '0;
                        step_q    <= OUT_RD;
                        mem_ren_q <= 1'b1;
                        state_q   <= DATA_OUT;
                    end
                end
                DATA_OUT: begin
                    case (step_q)
                        OUT_RD:  step_q <= OUT_CAP;
                        OUT_CAP: begin
                            hold_q    <= mem_rdata;
                            out_vld_q <= 1'b1;
                            step_q    <= OUT_LO;
                        end
                        OUT_LO: begin
                            if (out_rdy) step_q <= OUT_HI;
                        end
                        OUT_HI: begin
                            if (out_rdy) begin
                                out_vld_q <= 1'b0;
                                step_q    <= OUT_RD;
                                if (cnt_q == cfg_q[CFG_NOUT]) begin
                                    cnt_q    <= '0;
                                    in_rdy_q <= 1'b1;
                                    state_q  <= DATA_IN;
                                end else begin
                                    cnt_q     <= cnt_d;
                                    mem_ren_q <= 1'b1;
                                end
                            end
                        end
                        default: step_q <= OUT_RD;
                    endcase
                end
                default: state_q <= CFG;
            endcase
        end
    end

    assign in_rdy      = in_rdy_q;
    assign out_vld     = out_vld_q;
    assign out_data    = (step_q == OUT_HI) ? hold_q[31:16] : hold_q[15:0];
    assign core_start  = core_start_q;
    assign instr_wen   = pk_word_vld && (state_q == INSTR);
    assign instr_addr  = IADDR_W'(cnt_q);
    assign instr_wdata = pk_word;
    // Writes only happen in DATA_IN and reads only in DATA_OUT, so the strobes never overlap.
    assign mem_wen     = pk_word_vld && (state_q == DATA_IN);
    assign mem_ren     = mem_ren_q;
    assign mem_addr    = (state_q == DATA_OUT) ? cfg_q[CFG_OUTBASE] + cnt_q
                                               : cfg_q[CFG_INBASE] + cnt_q;
    assign mem_wdata   = pk_word;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_io_stream_loader.sv
// Self-checking bench for io_stream_loader: random instructions, batches and
// results checked against queue-based expectations derived from the config.
module tb_io_stream_loader;
    import loader_pkg::*;

    localparam int IADDR_W = 8;
    localparam int DADDR_W = 12;
    localparam int TO      = 400;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [15:0]        in_data;
    logic               in_vld;
    logic               in_rdy;
    logic [15:0]        out_data;
    logic               out_vld;
    logic               out_rdy;
    logic               instr_wen;
    logic [IADDR_W-1:0] instr_addr;
    logic [31:0]        instr_wdata;
    logic               mem_wen;
    logic               mem_ren;
    logic [DADDR_W-1:0] mem_addr;
    logic [31:0]        mem_wdata;
    logic [31:0]        mem_rdata;
    logic               core_start;
    logic               core_done;
    logic [2:0]         dbg_state;

    io_stream_loader #(.NUM_CONFIGS(5), .IADDR_W(IADDR_W), .DADDR_W(DADDR_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_vld      (in_vld),
        .in_rdy      (in_rdy),
        .out_data    (out_data),
        .out_vld     (out_vld),
        .out_rdy     (out_rdy),
        .instr_wen   (instr_wen),
        .instr_addr  (instr_addr),
        .instr_wdata (instr_wdata),
        .mem_wen     (mem_wen),
        .mem_ren     (mem_ren),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .core_start  (core_start),
        .core_done   (core_done),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int tests_run    = 0;
    int tests_failed = 0;

    logic [63:0] exp_instr_q[$];
    logic [63:0] exp_wr_q[$];
    logic [15:0] exp_q[$];

    int instr_seen  = 0;
    int halves_seen = 0;
    int start_cnt   = 0;

    // model of the current configuration
    int n_instr_m, n_in_m, in_base_m, n_out_m, out_base_m;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- memory model ----------------
    logic [31:0] dmem [4096];
    logic        bk_wen = 1'b0;
    logic [11:0] bk_addr = '0;
    logic [31:0] bk_data = '0;

    always @(posedge clk) begin
        if (mem_wen) dmem[mem_addr] <= mem_wdata;
        if (bk_wen) dmem[bk_addr] <= bk_data;
        if (mem_ren) mem_rdata <= dmem[mem_addr];
    end

    // ---------------- out_rdy driver ----------------
    logic stall_req   = 1'b0;
    logic stall_taken = 1'b0;
    logic rdy_random  = 1'b0;
    int   stall_left  = 0;

    initial begin
        out_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (stall_req && !stall_taken) begin
                stall_left  = 10;
                stall_taken = 1'b1;
            end
            if (stall_left > 0) begin
                out_rdy = 1'b0;
                stall_left--;
            end else begin
                out_rdy = rdy_random ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    end

    // ---------------- monitors ----------------
    logic        prev_vld = 1'b0;
    logic        prev_rdy = 1'b0;
    logic [15:0] prev_data = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (instr_wen) begin
                instr_seen++;
                if (exp_instr_q.size() == 0) check("instr_extra", 64'd1, 64'd0);
                else check("instr_wr", {instr_addr, instr_wdata}, exp_instr_q.pop_front());
            end
            if (mem_wen) begin
                if (exp_wr_q.size() == 0) check("mem_wr_extra", 64'd1, 64'd0);
                else check("mem_wr", {mem_addr, mem_wdata}, exp_wr_q.pop_front());
            end
            if (mem_ren) check("ren_wen_excl", 64'(mem_wen), 64'd0);
            if (core_start) start_cnt++;
            if (prev_vld && !prev_rdy) check("out_hold", {out_vld, out_data}, {1'b1, prev_data});
            if (out_vld && out_rdy) begin
                halves_seen++;
                if (exp_q.size() == 0) check("out_extra", 64'd1, 64'd0);
                else check("out_half", out_data, exp_q.pop_front());
                if (halves_seen == 1) stall_req = 1'b1;
            end
            prev_vld  = out_vld;
            prev_rdy  = out_rdy;
            prev_data = out_data;
        end else begin
            prev_vld = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_half(input logic [15:0] d);
        int n;
        n = 0;
        in_data = d;
        in_vld  = 1'b1;
        while (!in_rdy && n < TO) begin
            @(negedge clk);
            n++;
        end
        if (!in_rdy) check("in_rdy_timeout", 64'(in_rdy), 64'd1);
        @(negedge clk);
        in_vld = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_half(w[15:0]);
        send_half(w[31:16]);
    endtask

    task automatic send_cfg(input logic [15:0] c0, input logic [15:0] c1, input logic [15:0] c2,
                            input logic [15:0] c3, input logic [15:0] c4);
        n_instr_m  = int'(c0 & 16'h0fff) + 1;
        n_in_m     = int'(c1 & 16'h0fff) + 1;
        in_base_m  = int'(c2 & 16'h0fff);
        n_out_m    = int'(c3 & 16'h0fff) + 1;
        out_base_m = int'(c4 & 16'h0fff);
        send_half(c0);
        send_half(c1);
        send_half(c2);
        send_half(c3);
        send_half(c4);
    endtask

    task automatic load_instr();
        logic [31:0] w;
        for (int k = 0; k < n_instr_m; k++) begin
            w = (k == 0) ? 32'h1234_5678 : $urandom;
            exp_instr_q.push_back({24'd0, 8'(k % 256), w});
            send_word(w);
        end
    endtask

    task automatic send_batch_words(input int nw);
        logic [31:0] w;
        for (int k = 0; k < nw; k++) begin
            w = $urandom;
            exp_wr_q.push_back({20'd0, 12'((in_base_m + k) % 4096), w});
            send_word(w);
        end
    endtask

    task automatic bk_write(input int a, input logic [31:0] d);
        bk_addr = 12'(a);
        bk_data = d;
        bk_wen  = 1'b1;
        @(negedge clk);
        bk_wen  = 1'b0;
    endtask

    task automatic run_batch(input int b);
        int          n;
        logic [31:0] r;
        send_batch_words(n_in_m);
        n = 0;
        while (!core_start && n < TO) begin
            @(negedge clk);
            n++;
        end
        check("core_start_seen", 64'(core_start), 64'd1);
        check("in_writes_done", 64'(exp_wr_q.size()), 64'd0);
        @(negedge clk);
        check("compute_state", 64'(dbg_state), 64'(COMPUTE));
        // the core's results: written into memory, expected back low half first
        for (int k = 0; k < n_out_m; k++) begin
            r = (b == 0 && k == 0) ? 32'hAAAA_5555 : $urandom;
            bk_write((out_base_m + k) % 4096, r);
            exp_q.push_back(r[15:0]);
            exp_q.push_back(r[31:16]);
        end
        repeat ($urandom_range(0, 4)) @(negedge clk);
        check("compute_in_rdy", 64'(in_rdy), 64'd0);
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < TO * 10) begin
            @(negedge clk);
            n++;
        end
        check("out_drained", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);
        check("back_to_data_in", 64'(dbg_state), 64'(DATA_IN));
        check("data_in_rdy", 64'(in_rdy), 64'd1);
    endtask

    task automatic check_outputs_idle(input string tag);
        check({tag, "_in_rdy"}, 64'(in_rdy), 64'd0);
        check({tag, "_out_vld"}, 64'(out_vld), 64'd0);
        check({tag, "_out_data"}, 64'(out_data), 64'd0);
        check({tag, "_strobes"}, {instr_wen, mem_wen, mem_ren, core_start}, 64'd0);
        check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        check({tag, "_state"}, 64'(dbg_state), 64'(CFG));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n     = 1'b0;
        in_vld    = 1'b0;
        in_data   = '0;
        core_done = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_idle("reset");
        rst_n = 1'b1;
        @(negedge clk);

        send_cfg(16'h007d, 16'h0017, 16'h07d0, 16'h0017, 16'h07e8);
        check("cfg_to_instr", 64'(dbg_state), 64'(INSTR));

        load_instr();
        repeat (2) @(negedge clk);
        check("instr_count", 64'(instr_seen), 64'd126);
        check("instr_all_seen", 64'(exp_instr_q.size()), 64'd0);
        check("instr_to_data_in", 64'(dbg_state), 64'(DATA_IN));

        // a stray core_done outside COMPUTE must be ignored
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        repeat (2) @(negedge clk);
        check("stray_done_state", 64'(dbg_state), 64'(DATA_IN));
        check("stray_done_start", 64'(start_cnt), 64'd0);

        for (int b = 0; b < 5; b++) begin
            run_batch(b);
            rdy_random = 1'b1;
        end
        check("five_batches_starts", 64'(start_cnt), 64'd5);
        check("five_batches_halves", 64'(halves_seen), 64'd240);

        // reset in the middle of an inbound batch
        send_batch_words(10);
        @(negedge clk);
        check("partial_writes", 64'(exp_wr_q.size()), 64'd0);
        rst_n = 1'b0;
        #1;
        check_outputs_idle("midrst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // small config with base addresses that wrap past the top of memory
        send_cfg(16'h0001, 16'h0001, 16'hffff, 16'h0001, 16'h0fff);
        check("recfg_to_instr", 64'(dbg_state), 64'(INSTR));
        load_instr();
        repeat (2) @(negedge clk);
        check("reinstr_to_data_in", 64'(dbg_state), 64'(DATA_IN));
        run_batch(5);

        check("total_starts", 64'(start_cnt), 64'd6);
        check("total_halves", 64'(halves_seen), 64'd244);
        check("queues_empty", 64'(exp_instr_q.size() + exp_wr_q.size() + exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
